bram_1rw_arbiter: RTL

BRAM_1RW_ARBITER -- requirements
Module: bram_1rw_arbiter

---
 rtl/bram_arb_pkg.sv | 11 +
 rtl/bram_arb_rsp.sv | 60 ++++++
 rtl/bram_1rw_arbiter.sv | 128 ++++++++++++
 3 files changed

// File: rtl/bram_arb_pkg.sv
// Shared constants and response-state encoding for the two-port 1RW BRAM arbiter.
package bram_arb_pkg;

  localparam int unsigned NUM_PORTS = 2;

  typedef enum logic {
    RSP_EMPTY = 1'b0,
    RSP_HELD  = 1'b1
  } rsp_state_e;

endpackage

// File: rtl/bram_arb_rsp.sv
// One port's read-response path: presents MEM_DOUT the cycle after a read grant and
// holds it in a skid register while the requester stalls.
module bram_arb_rsp
  import bram_arb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rd_grant,
  input  logic                  rsp_rdy,
  input  logic [DATA_WIDTH-1:0] mem_dout,
  output logic                  rsp_val_c,
  output logic [DATA_WIDTH-1:0] rsp_data_c,
  output logic                  rd_ok_c
);

  rsp_state_e            state;
  rsp_state_e            state_next;
  logic                  inflight;
  logic                  capture;
  logic [DATA_WIDTH-1:0] hold_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= RSP_EMPTY;
      inflight  <= 1'b0;
      hold_data <= '0;
    end else begin
      state    <= state_next;
      inflight <= rd_grant;
      if (capture) hold_data <= mem_dout;
    end
  end

  // A new read may issue only when the previous response leaves this cycle.
  always_comb begin
    state_next = state;
    capture    = 1'b0;
    rsp_val_c  = 1'b0;
    rsp_data_c = mem_dout;
    rd_ok_c    = 1'b0;
    case (state)
      RSP_EMPTY: begin
        rsp_val_c = inflight;
        rd_ok_c   = !inflight || rsp_rdy;
        if (inflight && !rsp_rdy) begin
          state_next = RSP_HELD;
          capture    = 1'b1;
        end
      end
      RSP_HELD: begin
        rsp_val_c  = 1'b1;
        rsp_data_c = hold_data;
        if (rsp_rdy) state_next = RSP_EMPTY;
      end
    endcase
  end

endmodule

// File: rtl/bram_1rw_arbiter.sv
// Two-requester arbiter in front of a single-port (1RW) memory with latency-1 reads.
// Define BRAM_ARB_RR_EN for round-robin tie breaking; otherwise port 0 always wins ties.
module bram_1rw_arbiter
  import bram_arb_pkg::*;
#(
  parameter int unsigned DEPTH         = 512,
  parameter int unsigned ADDR_WIDTH    = 9,
  parameter int unsigned BITMASK_WIDTH = 32,
  parameter int unsigned DATA_WIDTH    = 32
) (
  input  logic                     MEMCLK,
  input  logic                     RESET,
  input  logic                     REQ_VAL_0,
  input  logic                     REQ_VAL_1,
  output logic                     REQ_RDY_0,
  output logic                     REQ_RDY_1,
  input  logic                     REQ_WEN_0,
  input  logic                     REQ_WEN_1,
  input  logic [ADDR_WIDTH-1:0]    REQ_ADDR_0,
  input  logic [ADDR_WIDTH-1:0]    REQ_ADDR_1,
  input  logic [BITMASK_WIDTH-1:0] REQ_BW_0,
  input  logic [BITMASK_WIDTH-1:0] REQ_BW_1,
  input  logic [DATA_WIDTH-1:0]    REQ_DATA_0,
  input  logic [DATA_WIDTH-1:0]    REQ_DATA_1,
  output logic                     RSP_VAL_0,
  output logic                     RSP_VAL_1,
  input  logic                     RSP_RDY_0,
  input  logic                     RSP_RDY_1,
  output logic [DATA_WIDTH-1:0]    RSP_DATA_0,
  output logic [DATA_WIDTH-1:0]    RSP_DATA_1,
  output logic                     MEM_CE,
  output logic                     MEM_RDWEN,
  output logic [ADDR_WIDTH-1:0]    MEM_A,
  output logic [BITMASK_WIDTH-1:0] MEM_BW,
  output logic [DATA_WIDTH-1:0]    MEM_DIN,
  input  logic [DATA_WIDTH-1:0]    MEM_DOUT
);

  if (DEPTH > (64'd1 << ADDR_WIDTH)) begin : g_depth_check
    $error("DEPTH does not fit in ADDR_WIDTH");
  end

  logic [NUM_PORTS-1:0] val;
  logic [NUM_PORTS-1:0] wen;
  logic [NUM_PORTS-1:0] rsp_rdy;
  logic [NUM_PORTS-1:0] rd_ok;
  logic [NUM_PORTS-1:0] elig;
  logic [NUM_PORTS-1:0] grant;
  logic [NUM_PORTS-1:0] rd_grant;

  assign val      = {REQ_VAL_1, REQ_VAL_0};
  assign wen      = {REQ_WEN_1, REQ_WEN_0};
  assign rsp_rdy  = {RSP_RDY_1, RSP_RDY_0};
  assign elig     = val & (wen | rd_ok);
  assign rd_grant = grant & ~wen;
  assign REQ_RDY_0 = grant[0];
  assign REQ_RDY_1 = grant[1];

`ifdef BRAM_ARB_RR_EN
  logic last_grant;

  // Remembers which port won most recently; reset favours port 0 on the first tie.
  always_ff @(posedge MEMCLK or posedge RESET) begin
    if (RESET)       last_grant <= 1'b1;
    else if (|grant) last_grant <= grant[1];
  end
`endif

  always_comb begin
    grant = '0;
    if (!RESET) begin
      if (&elig) begin
`ifdef BRAM_ARB_RR_EN
        grant = last_grant ? 2'b01 : 2'b10;
`else
        grant = 2'b01;
`endif
      end else begin
        grant = elig;
      end
    end
  end

  // Memory command mux; idle cycles drive zeros.
  always_comb begin
    MEM_CE    = 1'b0;
    MEM_RDWEN = 1'b1;
    MEM_A     = '0;
    MEM_BW    = '0;
    MEM_DIN   = '0;
    if (grant[0]) begin
      MEM_CE    = 1'b1;
      MEM_RDWEN = ~REQ_WEN_0;
      MEM_A     = REQ_ADDR_0;
      MEM_BW    = REQ_BW_0;
      MEM_DIN   = REQ_DATA_0;
    end else if (grant[1]) begin
      MEM_CE    = 1'b1;
      MEM_RDWEN = ~REQ_WEN_1;
      MEM_A     = REQ_ADDR_1;
      MEM_BW    = REQ_BW_1;
      MEM_DIN   = REQ_DATA_1;
    end
  end

  bram_arb_rsp #(.DATA_WIDTH(DATA_WIDTH)) u_rsp_0 (
    .clk        (MEMCLK),
    .rst        (RESET),
    .rd_grant   (rd_grant[0]),
    .rsp_rdy    (rsp_rdy[0]),
    .mem_dout   (MEM_DOUT),
    .rsp_val_c  (RSP_VAL_0),
    .rsp_data_c (RSP_DATA_0),
    .rd_ok_c    (rd_ok[0])
  );

  bram_arb_rsp #(.DATA_WIDTH(DATA_WIDTH)) u_rsp_1 (
    .clk        (MEMCLK),
    .rst        (RESET),
    .rd_grant   (rd_grant[1]),
    .rsp_rdy    (rsp_rdy[1]),
    .mem_dout   (MEM_DOUT),
    .rsp_val_c  (RSP_VAL_1),
    .rsp_data_c (RSP_DATA_1),
    .rd_ok_c    (rd_ok[1])
  );

endmodule
